// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle RV32I data memory with req/ready handshake, wait states and B/H/W access.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning them.
module data_mem_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   localparam int DEPTH = 2 ** (ADDR_W - 2);
   localparam bit DIRECT = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic we_q, err_q;
   logic [2:0] f3_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [31:0] mem [DEPTH];
   logic accept, commit, c_we, legal, misal, rej, sx;
   logic [2:0] c_f3;
   logic [31:0] c_addr, c_wdata, word, wd, rd;
   logic [3:0] be;
   logic [7:0] ld_b;
   logic [15:0] ld_h;
   logic [ADDR_W-3:0] idx;
   assign accept = req_i && state_q == IDLE;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = DIRECT ? DONE : WAIT;
         cnt_d   = CNT_INIT;
      end else if (state_q == WAIT) begin
         state_d = cnt_q == '0 ? DONE : WAIT;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   // With no wait states the access commits on the accept edge, so it must use the live inputs.
   assign c_we    = DIRECT ? we_i : we_q;
   assign c_f3    = DIRECT ? funct3_i : f3_q;
   assign c_addr  = DIRECT ? addr_i : addr_q;
   assign c_wdata = DIRECT ? wdata_i : wdata_q;
   assign commit  = rst_n && ((state_q == WAIT && cnt_q == '0) || (accept && DIRECT));
   assign idx     = c_addr[ADDR_W-1:2];
   assign word    = mem[idx];
   assign legal   = c_f3[1:0] != 2'b11 && (c_we ? !c_f3[2] : !(c_f3[2] && c_f3[1]));
`ifdef DMEM_MISALIGN_TRAP_EN
   assign misal   = (c_f3[1:0] == 2'b01 && c_addr[0]) || (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
`else
   assign misal   = 1'b0;
`endif
   assign rej     = (|c_addr[31:ADDR_W]) || !legal || misal;
   assign be      = c_f3[1] ? 4'hF : c_f3[0] ? (c_addr[1] ? 4'hC : 4'h3) : 4'b0001 << c_addr[1:0];
   assign wd      = c_f3[1] ? c_wdata : c_f3[0] ? {2{c_wdata[15:0]}} : {4{c_wdata[7:0]}};
   assign ld_b    = 8'(word >> {c_addr[1:0], 3'b000});
   assign ld_h    = c_addr[1] ? word[31:16] : word[15:0];
   assign sx      = !c_f3[2];
   assign rd      = c_f3[1] ? word : c_f3[0] ? {{16{sx & ld_h[15]}}, ld_h} : {{24{sx & ld_b[7]}}, ld_b};
   always_ff @(posedge clk) begin
      if (commit && c_we && !rej)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= we_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
         end
         if (commit) begin
            err_q   <= rej;
            rdata_q <= (rej || c_we) ? '0 : rd;
         end
      end
   end
   assign ready_o  = state_q == IDLE;
   assign rvalid_o = state_q == DONE;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q && state_q == DONE;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl (ADDR_W=12, WAIT_CYCLES=2).
module tb_data_mem_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [2:0] funct3_i = '0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic ready_o, rvalid_o, err_o;
   logic [31:0] rdata_o;
   int checks = 0, errors = 0;
   logic [31:0] rd;
   logic e;
   int rv_k, lo, nrv, cnt;

   data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs are scrambled right after accept so a design that fails to latch them is exposed.
   task automatic acc(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input bit pulse, output logic [31:0] r, output logic er,
                      output int k_rv, output int n_lo, output int n_rv);
      @(negedge clk);
      req_i = 1'b1; we_i = w; funct3_i = f; addr_i = a; wdata_i = d;
      @(posedge clk);
      #1;
      req_i = 1'b0; we_i = ~w; funct3_i = 3'b111; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5A5A_A5A5;
      k_rv = 0; n_lo = 0; n_rv = 0; r = 'x; er = 1'bx;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (rvalid_o) begin
            n_rv++; k_rv = k; r = rdata_o; er = err_o;
         end
         if (!ready_o) n_lo++;
         else break;
         if (pulse && k == 1) begin
            req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0; wdata_i = 32'h0000_0BAD;
         end
         if (k == 2) req_i = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      rst_n = 1'b1;

      acc(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, e, rv_k, lo, nrv);
      chk("sw_rv_cycle", 32'(rv_k), 32'd4);
      chk("sw_ready_low", 32'(lo), 32'd4);
      chk("sw_rv_count", 32'(nrv), 32'd1);
      chk("sw_err", 32'(e), 32'd0);
      chk("sw_rdata", rd, 32'd0);
      acc(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lw_rdata", rd, 32'hDEAD_BEEF);
      chk("lw_err", 32'(e), 32'd0);
      chk("lw_rv_cycle", 32'(rv_k), 32'd4);
      chk("lw_ready_low", 32'(lo), 32'd4);
      chk("rdata_held", rdata_o, 32'hDEAD_BEEF);

      acc(1'b1, 3'b000, 32'h13, 32'h0000_0080, 1'b0, rd, e, rv_k, lo, nrv);
      acc(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lb", rd, 32'hFFFF_FF80);
      acc(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lbu", rd, 32'h0000_0080);
      acc(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lw_after_sb", rd, 32'h80AD_BEEF);

      acc(1'b1, 3'b001, 32'h12, 32'h0000_8001, 1'b0, rd, e, rv_k, lo, nrv);
      acc(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lh", rd, 32'hFFFF_8001);
      acc(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lhu", rd, 32'h0000_8001);
      acc(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lw_after_sh", rd, 32'h8001_BEEF);

      acc(1'b1, 3'b010, 32'h0, 32'h1234_5678, 1'b0, rd, e, rv_k, lo, nrv);
      acc(1'b1, 3'b010, 32'h1000, 32'h1, 1'b1, rd, e, rv_k, lo, nrv);
      chk("sw_oob_err", 32'(e), 32'd1);
      chk("sw_oob_rvalid", 32'(nrv), 32'd1);
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (rvalid_o) cnt++;
      end
      chk("wait_req_ignored", 32'(cnt), 32'd0);
      acc(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      acc(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("bad_f3_err", 32'(e), 32'd1);
      chk("bad_f3_rdata", rd, 32'd0);
      acc(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("lw0_unchanged", rd, 32'h1234_5678);
      chk("lw0_err", 32'(e), 32'd0);

      acc(1'b0, 3'b010, 32'h11, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lw_misal_err", 32'(e), 32'd1);
      chk("lw_misal_rdata", rd, 32'd0);
`else
      chk("lw_misal_err", 32'(e), 32'd0);
      chk("lw_misal_rdata", rd, 32'h8001_BEEF);
`endif

      acc(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 1'b0, rd, e, rv_k, lo, nrv);
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h20; wdata_i = 32'h55;
      @(posedge clk);
      #1 req_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(ready_o), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(ready_o), 32'd1);
      chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid_o) cnt++;
      end
      chk("midrst_no_rvalid", 32'(cnt), 32'd0);
      chk("midrst_ready_after", 32'(ready_o), 32'd1);
      acc(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, e, rv_k, lo, nrv);
      chk("midrst_store_dropped", rd, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
